mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter.sv | 91 +++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU-side definitions for the instruction/data memory port arbiter.
// Response owner encoding and byte-strobe width.
package mem_port_arbiter_pkg;

  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_INST = 2'b01,
    OWN_DATA = 2'b10
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto one single-port SRAM
// (1-cycle read latency). Data wins by default; a starve counter lets inst through.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [31:0]       inst_rdata,

  input  logic              data_req,
  input  logic [STRB_W-1:0] data_we,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [31:0]       data_rdata,

  output logic              sram_en,
  output logic [STRB_W-1:0] sram_we,
  output logic [31:0]       sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0] r_starve_cnt;
  owner_e           r_owner;

  logic w_inst_pri;
  logic w_inst_gnt;
  logic w_data_gnt;

  // Grants are combinational so an access can issue every cycle with no bubble.
  always_comb begin
    w_inst_pri = (r_starve_cnt == LIMIT_C);
    w_data_gnt = !reset && data_req && !(inst_req && w_inst_pri);
    w_inst_gnt = !reset && inst_req && !w_data_gnt;
  end

  always_comb begin
    sram_en    = w_inst_gnt || w_data_gnt;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = data_wdata;
    if (w_data_gnt) begin
      sram_we   = data_we;
      sram_addr = data_addr;
    end else if (w_inst_gnt) begin
      sram_addr = inst_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner      <= OWN_NONE;
      r_starve_cnt <= '0;
    end else begin
      if (w_inst_gnt)
        r_owner <= OWN_INST;
      else if (w_data_gnt && (data_we == '0))
        r_owner <= OWN_DATA;
      else
        r_owner <= OWN_NONE;

      // Only counts data grants that actually made a waiting fetch wait longer.
      if (!inst_req || w_inst_gnt)
        r_starve_cnt <= '0;
      else if (w_data_gnt && (r_starve_cnt != LIMIT_C))
        r_starve_cnt <= r_starve_cnt + ONE_C;
    end
  end

  // Gated by reset so a read in flight at reset never completes.
  assign inst_rvalid = !reset && (r_owner == OWN_INST);
  assign data_rvalid = !reset && (r_owner == OWN_DATA);
  assign inst_rdata  = sram_rdata;
  assign data_rdata  = sram_rdata;
  assign inst_gnt    = w_inst_gnt;
  assign data_gnt    = w_data_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: SRAM model, response scoreboard,
// immediate-assertion checks of grants, SRAM drive and read responses.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam logic [31:0] IA  = 32'h1C00_0000;
  localparam logic [31:0] DA  = 32'h0000_0100;

  typedef struct {
    owner_e      own;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic [31:0] sram_mem [0:255];
  logic [31:0] exp_mem  [0:255];
  resp_t       sb_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_gnt    (inst_gnt),
    .inst_rvalid (inst_rvalid),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // Single-port SRAM, one cycle read latency, byte-strobed writes.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we == 4'b0000)
        sram_rdata <= sram_mem[widx(sram_addr)];
      else
        for (int b = 0; b < 4; b++)
          if (sram_we[b])
            sram_mem[widx(sram_addr)][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_resp();
    resp_t r;
    if (sb_q.size() == 0) return;
    r = sb_q.pop_front();
    chk("inst_rvalid", 32'(inst_rvalid), 32'(r.own == OWN_INST));
    chk("data_rvalid", 32'(data_rvalid), 32'(r.own == OWN_DATA));
    if (r.own != OWN_NONE) begin
      chk("inst_rdata", inst_rdata, r.data);
      chk("data_rdata", data_rdata, r.data);
    end
  endtask

  // One clock cycle: drive requests, check grant/SRAM drive mid-cycle,
  // check the previous cycle's response, queue this cycle's expected response.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr,
                      input logic [3:0] dwe, input logic [31:0] da,
                      input logic [31:0] dwd, input owner_e exp);
    resp_t r;
    inst_req = ir; inst_addr = ia;
    data_req = dr; data_we = dwe; data_addr = da; data_wdata = dwd;
    @(negedge clk);
    check_resp();
    chk("inst_gnt", 32'(inst_gnt), 32'(exp == OWN_INST));
    chk("data_gnt", 32'(data_gnt), 32'(exp == OWN_DATA));
    chk("sram_en", 32'(sram_en), 32'(exp != OWN_NONE));
    r.own  = OWN_NONE;
    r.data = 32'h0;
    case (exp)
      OWN_INST: begin
        chk("sram_addr", sram_addr, ia);
        chk("sram_we", 32'(sram_we), 32'h0);
        r.own  = OWN_INST;
        r.data = exp_mem[widx(ia)];
      end
      OWN_DATA: begin
        chk("sram_addr", sram_addr, da);
        chk("sram_we", 32'(sram_we), 32'(dwe));
        if (dwe == 4'b0000) begin
          r.own  = OWN_DATA;
          r.data = exp_mem[widx(da)];
        end else begin
          chk("sram_wdata", sram_wdata, dwd);
          for (int b = 0; b < 4; b++)
            if (dwe[b]) exp_mem[widx(da)][8*b +: 8] = dwd[8*b +: 8];
        end
      end
      default: begin
        chk("sram_addr", sram_addr, 32'h0);
        chk("sram_we", 32'(sram_we), 32'h0);
      end
    endcase
    sb_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, OWN_NONE);
  endtask

  // Holds reset with the current requests still driven; nothing may leak out.
  task automatic apply_reset(input int ncyc);
    resp_t r;
    reset = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      chk("rst_inst_gnt", 32'(inst_gnt), 32'h0);
      chk("rst_data_gnt", 32'(data_gnt), 32'h0);
      chk("rst_inst_rvalid", 32'(inst_rvalid), 32'h0);
      chk("rst_data_rvalid", 32'(data_rvalid), 32'h0);
      chk("rst_sram_en", 32'(sram_en), 32'h0);
      chk("rst_sram_we", 32'(sram_we), 32'h0);
      chk("rst_sram_addr", sram_addr, 32'h0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    sb_q.delete();
    r.own  = OWN_NONE;
    r.data = 32'h0;
    sb_q.push_back(r);
  endtask

  task automatic starve_run(input int n, input int inst_at);
    owner_e e;
    for (int i = 0; i < n; i++) begin
      e = ((i % 5) == inst_at) ? OWN_INST : OWN_DATA;
      step(1'b1, IA, 1'b1, 4'h0, DA, 32'h0, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = 32'h5A00_0000 + i;
      exp_mem[i]  = 32'h5A00_0000 + i;
    end
    sram_mem[widx(32'h100)]      = 32'hDEAD_BEEF;
    sram_mem[widx(IA)]           = 32'hCAFE_F00D;
    sram_mem[widx(32'h80)]       = 32'h0BAD_C0DE;
    sram_mem[widx(32'h200)]      = 32'hAAAA_BBBB;
    exp_mem[widx(32'h100)]       = 32'hDEAD_BEEF;
    exp_mem[widx(IA)]            = 32'hCAFE_F00D;
    exp_mem[widx(32'h80)]        = 32'h0BAD_C0DE;
    exp_mem[widx(32'h200)]       = 32'hAAAA_BBBB;

    inst_req = 1'b1; inst_addr = IA;
    data_req = 1'b1; data_we = 4'h0; data_addr = DA; data_wdata = 32'h0;
    apply_reset(2);

    // First cycle out of reset grants; data read of 0x100.
    step(1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0, OWN_DATA);
    idle();

    // Byte-strobed write, then readback of the merged word.
    step(1'b0, 32'h0, 1'b1, 4'b0011, 32'h200, 32'h1234_5678, OWN_DATA);
    idle();
    step(1'b0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0, OWN_DATA);
    idle();
    chk("wr_merge_exp", exp_mem[widx(32'h200)], 32'hAAAA_5678);

    // Inst then data back to back.
    step(1'b1, IA, 1'b0, 4'h0, 32'h0, 32'h0, OWN_INST);
    step(1'b0, 32'h0, 1'b1, 4'h0, 32'h80, 32'h0, OWN_DATA);
    idle();

    // Both requesting continuously: D,D,D,D,I repeating.
    starve_run(10, 4);
    idle();

    // Data writes while inst waits still count toward starvation.
    step(1'b1, IA, 1'b1, 4'b1111, 32'h40, 32'h1111_2222, OWN_DATA);
    step(1'b1, IA, 1'b1, 4'b1000, 32'h44, 32'h3300_0000, OWN_DATA);
    step(1'b1, IA, 1'b1, 4'h0, 32'h40, 32'h0, OWN_DATA);
    step(1'b1, IA, 1'b1, 4'h0, 32'h44, 32'h0, OWN_DATA);
    step(1'b1, IA, 1'b1, 4'h0, DA, 32'h0, OWN_INST);
    idle();

    // inst_req dropped after 3 data grants: counter restarts.
    starve_run(3, 9);
    step(1'b0, 32'h0, 1'b1, 4'h0, DA, 32'h0, OWN_DATA);
    starve_run(5, 4);
    idle();

    // Reset with a partial count: counter restarts at 0.
    starve_run(3, 9);
    apply_reset(1);
    starve_run(5, 4);

    // Reset the cycle after an inst grant: its read is discarded.
    step(1'b1, IA, 1'b0, 4'h0, 32'h0, 32'h0, OWN_INST);
    apply_reset(2);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
